xor_lane_array: RTL and testbench
=================================

Name: xor_lane_array

Overview:
- Parametrised, registered multi-lane XOR stage: each lane computes c = a ^ b (or XNOR), with a valid/ready handshake and a one-entry output register.
- Each lane also checks its result against a per-lane expected value. It keeps a sticky mismatch flag and a saturating error counter.
- Used as a self-checking datapath slice in bind and hierarchy regression designs. Lanes are fully independent.

Parameters:
- LANES, 2, number of independent lanes (>=1).
- WIDTH, 1, data width per lane in bits (>=1).
- CNT_W, 8, width of each lane's error counter (>=1).
- INVERT, 0, 0 = XOR, 1 = XNOR (c = ~(a ^ b)); applies to all lanes.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  LANES  per-lane input valid.
- in_ready  output  LANES  per-lane input ready.
- a  input  LANES*WIDTH  operand A; lane i occupies bits [i*WIDTH +: WIDTH].
- b  input  LANES*WIDTH  operand B; same packing as a.
- exp  input  LANES*WIDTH  expected result, sampled together with a and b.
- out_valid  output  LANES  per-lane output valid.
- out_ready  input  LANES  per-lane output ready.
- c  output  LANES*WIDTH  registered result.
- mismatch  output  LANES  sticky per-lane mismatch flag.
- err_cnt  output  LANES*CNT_W  per-lane saturating mismatch count.
- clr  input  1  synchronous clear of all mismatch flags and err_cnt.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: out_valid = 0, c = 0, mismatch = 0, err_cnt = 0. in_ready follows its combinational equation.
- Reset mid-operation discards all held data immediately, without waiting for a clock edge.
- in_ready[i] = !out_valid[i] || out_ready[i]. This is combinational, with no dependency on in_valid.
- Accept: accept[i] = in_valid[i] && in_ready[i]. On that edge:
  - c lane i <= a_i ^ b_i (INVERT=0) or ~(a_i ^ b_i) (INVERT=1);
  - out_valid[i] <= 1.
- Drain: out_valid[i] && out_ready[i] && !accept[i] -> out_valid[i] <= 0; c holds its last value.
- Simultaneous drain and accept on the same edge: the new result replaces the old one and out_valid stays 1. This gives full throughput of one result per lane per cycle.
- Stall: out_valid[i] && !out_ready[i] -> in_ready[i] = 0. c and out_valid are held stable and no input is accepted.
- Latency: 1 cycle from accept to out_valid.
- Check: on accept[i], compute the result and compare it with exp_i (full WIDTH compare).
  - If they differ: mismatch[i] <= 1 and err_cnt[i] <= err_cnt[i] + 1.
  - err_cnt saturates at 2^CNT_W - 1 and never wraps.
  - mismatch[i] remains 1 until clr or reset.
- Compare timing: the compare uses the same-cycle inputs. The flag and counter update on the same edge as c.
- clr: when clr = 1 at an edge, all mismatch <= 0 and all err_cnt <= 0.
  - clr takes priority over a mismatch event in the same cycle; that event is not counted.
  - clr does not affect c, out_valid or the handshake.
- Lane independence: a stall, accept or mismatch on one lane never changes the state of any other lane.
- Unknown inputs: in_valid = 0 -> a, b and exp are ignored, and X on them must not propagate into state.

Test Plan:
- Reset/basic: rst_n low for 2 cycles, LANES=2, WIDTH=1, then lane0 a=1 b=0 exp=1 and lane1 a=1 b=1 exp=0 -> next cycle out_valid=2'b11, c=2'b01, mismatch=0, err_cnt=0.
- Backpressure: WIDTH=8, lane0 a=8'hF0 b=8'h0F accepted, out_ready=0 for 3 cycles -> c lane0 held at 8'hFF, in_ready[0]=0 throughout; lane1 keeps streaming unaffected.
- Throughput: out_ready=1 with in_valid=1 for 16 cycles using an incrementing a and b=8'hAA -> 16 results with no bubbles, each c = a^8'hAA, 1-cycle latency.
- Mismatch and saturation: CNT_W=3, feed 10 lane0 inputs with a wrong exp -> mismatch[0]=1, err_cnt lane0 = 7 (saturated), lane1 count stays 0.
- Clear priority: pulse clr in the same cycle as a mismatching accept -> mismatch=0, err_cnt=0 after the edge; c still updates and out_valid=1.
- XNOR mode and async reset: INVERT=1, a=4'b1100 b=4'b1010 -> c=4'b1001; then drop rst_n between edges while out_valid=1 -> out_valid=0 and c=0 immediately.

Source files
------------

// File: rtl/xor_lane_array.sv
// Multi-lane registered XOR/XNOR stage with per-lane valid/ready, a one-entry output register,
// and a per-lane result checker (sticky mismatch flag plus saturating error counter).
module xor_lane_array #(
    parameter int LANES  = 2,
    parameter int WIDTH  = 1,
    parameter int CNT_W  = 8,
    parameter int INVERT = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LANES-1:0]       in_valid,
    output logic [LANES-1:0]       in_ready,
    input  logic [LANES*WIDTH-1:0] a,
    input  logic [LANES*WIDTH-1:0] b,
    input  logic [LANES*WIDTH-1:0] exp,
    output logic [LANES-1:0]       out_valid,
    input  logic [LANES-1:0]       out_ready,
    output logic [LANES*WIDTH-1:0] c,
    output logic [LANES-1:0]       mismatch,
    output logic [LANES*CNT_W-1:0] err_cnt,
    input  logic                   clr
);

    // Handshake: a lane transfers on an edge where valid && ready are both high.
    // in_ready depends only on the output register state and out_ready, never on in_valid,
    // so an upstream producer may wait on in_ready without creating a combinational loop.

    localparam logic [WIDTH-1:0] INV_MASK = (INVERT != 0) ? '1 : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic             out_valid_q, out_valid_d;
        logic [WIDTH-1:0] c_q, c_d;
        logic             mismatch_q, mismatch_d;
        logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
        logic             ready;
        logic             accept;
        logic [WIDTH-1:0] result;
        logic             miss;

        always_comb begin
            ready       = !out_valid_q || out_ready[i];
            accept      = in_valid[i] && ready;
            result      = a[i*WIDTH +: WIDTH] ^ b[i*WIDTH +: WIDTH] ^ INV_MASK;
            // Gate the compare with accept so idle-cycle garbage on exp never reaches state.
            miss        = accept && (result != exp[i*WIDTH +: WIDTH]);

            out_valid_d = out_valid_q;
            c_d         = c_q;
            mismatch_d  = mismatch_q;
            err_cnt_d   = err_cnt_q;

            if (accept) begin
                out_valid_d = 1'b1;
                c_d         = result;
            end else if (out_valid_q && out_ready[i]) begin
                out_valid_d = 1'b0;
            end

            // A clear in the same cycle as a mismatch wins; that mismatch is dropped.
            if (clr) begin
                mismatch_d = 1'b0;
                err_cnt_d  = '0;
            end else if (miss) begin
                mismatch_d = 1'b1;
                if (err_cnt_q != CNT_MAX) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_valid_q <= 1'b0;
                c_q         <= '0;
                mismatch_q  <= 1'b0;
                err_cnt_q   <= '0;
            end else begin
                out_valid_q <= out_valid_d;
                c_q         <= c_d;
                mismatch_q  <= mismatch_d;
                err_cnt_q   <= err_cnt_d;
            end
        end

        assign in_ready[i]               = ready;
        assign out_valid[i]              = out_valid_q;
        assign c[i*WIDTH +: WIDTH]       = c_q;
        assign mismatch[i]               = mismatch_q;
        assign err_cnt[i*CNT_W +: CNT_W] = err_cnt_q;
    end

endmodule

// File: tb/tb_xor_lane_array.sv
// Self-checking bench for xor_lane_array: queue-based scoreboard with a behavioural lane model,
// directed scenarios for backpressure, throughput, saturation, clear priority, XNOR and async reset.
module tb_xor_lane_array;

    localparam int LANES = 2;
    localparam int W     = 8;
    localparam int CW    = 3;
    localparam int SAT   = (1 << CW) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT (XOR, 2 lanes x 8 bits, 3-bit counters) ----------------
    logic [LANES-1:0]    in_valid = '0;
    logic [LANES-1:0]    in_ready;
    logic [LANES*W-1:0]  a = '0, b = '0, expv = '0;
    logic [LANES-1:0]    out_valid;
    logic [LANES-1:0]    out_ready = '0;
    logic [LANES*W-1:0]  c;
    logic [LANES-1:0]    mismatch;
    logic [LANES*CW-1:0] err_cnt;
    logic                clr = 1'b0;

    xor_lane_array #(.LANES(LANES), .WIDTH(W), .CNT_W(CW), .INVERT(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .exp(expv), .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .mismatch(mismatch), .err_cnt(err_cnt), .clr(clr)
    );

    // ---------------- XNOR DUT (1 lane x 4 bits) ----------------
    logic       x_in_valid = 1'b0, x_in_ready;
    logic [3:0] x_a = '0, x_b = '0, x_exp = '0, x_c;
    logic       x_out_valid, x_out_ready = 1'b1, x_mismatch, x_clr = 1'b0;
    logic [7:0] x_err;

    xor_lane_array #(.LANES(1), .WIDTH(4), .CNT_W(8), .INVERT(1)) u_xnor (
        .clk(clk), .rst_n(rst_n), .in_valid(x_in_valid), .in_ready(x_in_ready),
        .a(x_a), .b(x_b), .exp(x_exp), .out_valid(x_out_valid), .out_ready(x_out_ready),
        .c(x_c), .mismatch(x_mismatch), .err_cnt(x_err), .clr(x_clr)
    );

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q [LANES][$];
    logic [W-1:0] last_c [LANES];
    logic         m_flag [LANES];
    int           m_err  [LANES];
    int           n_acc  [LANES];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < LANES; i++) begin
            exp_q[i].delete();
            last_c[i] = '0;
            m_flag[i] = 1'b0;
            m_err[i]  = 0;
        end
    endtask

    initial model_reset();

    // Model update at each active edge: drain, then accept, then checker bookkeeping.
    always @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                logic         acc;
                logic [W-1:0] res;
                acc = in_valid[i] && (exp_q[i].size() == 0 || out_ready[i]);
                if (exp_q[i].size() != 0 && out_ready[i]) void'(exp_q[i].pop_front());
                if (acc) begin
                    res = a[i*W +: W] ^ b[i*W +: W];
                    exp_q[i].push_back(res);
                    last_c[i] = res;
                    n_acc[i]++;
                    if (!clr && res != expv[i*W +: W]) begin
                        m_flag[i] = 1'b1;
                        if (m_err[i] < SAT) m_err[i]++;
                    end
                end
            end
            if (clr) begin
                for (int i = 0; i < LANES; i++) begin
                    m_flag[i] = 1'b0;
                    m_err[i]  = 0;
                end
            end
        end
    end

    // Monitor: away from the active edge, compare every lane against the model.
    always @(negedge clk) begin
        #1;
        for (int i = 0; i < LANES; i++) begin
            check($sformatf("in_ready[%0d]", i), 32'(in_ready[i]),
                  32'(exp_q[i].size() == 0 || out_ready[i]));
            check($sformatf("out_valid[%0d]", i), 32'(out_valid[i]), 32'(exp_q[i].size() != 0));
            if (exp_q[i].size() != 0)
                check($sformatf("c[%0d]", i), 32'(c[i*W +: W]), 32'(exp_q[i][0]));
            else
                check($sformatf("c_hold[%0d]", i), 32'(c[i*W +: W]), 32'(last_c[i]));
            check($sformatf("mismatch[%0d]", i), 32'(mismatch[i]), 32'(m_flag[i]));
            check($sformatf("err_cnt[%0d]", i), 32'(err_cnt[i*CW +: CW]), 32'(m_err[i]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic set_lane(input int i, input logic v, input logic [W-1:0] av,
                            input logic [W-1:0] bv, input logic [W-1:0] ev);
        in_valid[i]     = v;
        a[i*W +: W]    = av;
        b[i*W +: W]    = bv;
        expv[i*W +: W] = ev;
    endtask

    task automatic rand_lane(input int i, input bit good_exp);
        logic [W-1:0] av, bv;
        av = W'($urandom);
        bv = W'($urandom);
        set_lane(i, 1'($urandom_range(0, 1)), av, bv, good_exp ? (av ^ bv) : W'($urandom));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acc0;

        // Reset held for two edges; outputs must sit at reset values.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_c", 32'(c), 32'h0);
        check("rst_mismatch", 32'(mismatch), 32'h0);
        check("rst_err_cnt", 32'(err_cnt), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h3);
        cyc();
        rst_n = 1'b1;

        // Basic: one transfer per lane.
        out_ready = 2'b11;
        set_lane(0, 1'b1, 8'h01, 8'h00, 8'h01);
        set_lane(1, 1'b1, 8'h01, 8'h01, 8'h00);
        x_in_valid = 1'b1; x_a = 4'b1100; x_b = 4'b1010; x_exp = 4'b1001;
        cyc();
        #2;
        check("basic_out_valid", 32'(out_valid), 32'h3);
        check("basic_c", 32'(c), 32'h0001);
        check("basic_mismatch", 32'(mismatch), 32'h0);
        check("xnor_c", 32'(x_c), 32'h9);
        check("xnor_out_valid", 32'(x_out_valid), 32'h1);
        check("xnor_mismatch", 32'(x_mismatch), 32'h0);
        x_exp = 4'b0110;
        in_valid = '0;
        cyc();
        x_in_valid = 1'b0;
        #2;
        check("xnor_err", 32'(x_err), 32'h1);
        check("xnor_mismatch_set", 32'(x_mismatch), 32'h1);

        // Backpressure on lane 0 while lane 1 streams.
        set_lane(0, 1'b1, 8'hF0, 8'h0F, 8'hFF);
        cyc();
        out_ready[0] = 1'b0;
        set_lane(0, 1'b1, 8'h12, 8'h34, 8'h26);
        repeat (3) begin
            rand_lane(1, 1'b1);
            cyc();
            #2;
            check("stall_c0", 32'(c[7:0]), 32'hFF);
            check("stall_in_ready0", 32'(in_ready[0]), 32'h0);
        end
        out_ready = 2'b11;
        in_valid = '0;
        cyc();
        cyc();

        // Throughput: back-to-back accepts on lane 0, no bubbles.
        acc0 = n_acc[0];
        for (int k = 0; k < 16; k++) begin
            set_lane(0, 1'b1, W'(k), 8'hAA, W'(k) ^ 8'hAA);
            rand_lane(1, 1'b1);
            cyc();
            #2;
            check("tput_valid", 32'(out_valid[0]), 32'h1);
            check("tput_c", 32'(c[7:0]), 32'(W'(k) ^ 8'hAA));
        end
        check("tput_count", 32'(n_acc[0] - acc0), 32'd16);
        in_valid = '0;
        cyc();

        // Saturation: 10 wrong expectations on lane 0, lane 1 always right.
        for (int k = 0; k < 10; k++) begin
            set_lane(0, 1'b1, W'($urandom), W'($urandom), '0);
            expv[7:0] = ~(a[7:0] ^ b[7:0]);
            set_lane(1, 1'b1, W'(k), 8'h5A, W'(k) ^ 8'h5A);
            cyc();
        end
        in_valid = '0;
        #2;
        check("sat_err0", 32'(err_cnt[2:0]), 32'd7);
        check("sat_mismatch0", 32'(mismatch[0]), 32'h1);
        check("sat_err1", 32'(err_cnt[5:3]), 32'd0);
        check("sat_mismatch1", 32'(mismatch[1]), 32'h0);
        cyc();

        // Clear wins over a mismatching accept in the same cycle.
        clr = 1'b1;
        set_lane(0, 1'b1, 8'h03, 8'h05, 8'h00);
        cyc();
        clr = 1'b0;
        in_valid = '0;
        #2;
        check("clr_mismatch", 32'(mismatch), 32'h0);
        check("clr_err", 32'(err_cnt), 32'h0);
        check("clr_out_valid0", 32'(out_valid[0]), 32'h1);
        check("clr_c0", 32'(c[7:0]), 32'h06);
        cyc();

        // Randomised traffic with occasional clears and bad expectations.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < LANES; i++) rand_lane(i, $urandom_range(0, 3) != 0);
            out_ready = LANES'($urandom);
            clr = ($urandom_range(0, 39) == 0);
            cyc();
        end
        clr = 1'b0;

        // Asynchronous reset between edges while results are held.
        out_ready = '0;
        in_valid  = '1;
        cyc();
        in_valid = '0;
        #2;
        check("pre_arst_valid", 32'(out_valid), 32'h3);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_out_valid", 32'(out_valid), 32'h0);
        check("arst_c", 32'(c), 32'h0);
        check("arst_err", 32'(err_cnt), 32'h0);
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < LANES; i++) rand_lane(i, $urandom_range(0, 1) != 0);
            out_ready = LANES'($urandom);
            cyc();
        end
        in_valid = '0;
        out_ready = '1;
        cyc();
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
